pulse_gen: RTL and testbench

Step-pulse generator serving as the responder side of the motion command interface. It accepts a per-motor pulse count, motor select and direction vector from the upstream control block and emits step pulses on one of six stepper channels. It reports `Busy` for the full duration of a move so that upstream holds off the next command. It sits between the control block and the six stepper driver PUL/DIR pins.

---
 rtl/pulse_gen_if.sv | 29 ++
 rtl/pulse_gen.sv | 170 +++++++++++++++++
 tb/tb_pulse_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen_if
// Description : Motion command bundle between the control block (master)
//               and the step-pulse generator (slave). Also carries the
//               PUL/DIR outputs that go on to the stepper drivers.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_gen_if;
   logic       Enable;
   logic [2:0] Motor;
   logic [9:0] PulseNum;
   logic [5:0] DRs;
   logic [5:0] PULs;
   logic [5:0] DIRs;
   logic       Busy;
   logic       Done;

   modport master (
      output Enable, Motor, PulseNum, DRs,
      input  PULs, DIRs, Busy, Done
   );

   modport slave (
      input  Enable, Motor, PulseNum, DRs,
      output PULs, DIRs, Busy, Done
   );
endinterface
`default_nettype wire

// File: rtl/pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen
// Description : Step-pulse generator for six stepper channels. Accepts a
//               motor select, pulse count and direction vector in IDLE,
//               waits DIR_SETUP clocks after updating DIRs, then emits the
//               requested number of pulses on the selected PUL output.
//               Busy covers the whole move; Done strobes once at the end.
//               Optional macro PULSE_GEN_RAMP_EN enables a trapezoidal
//               speed ramp (4x half period at the ends, 1x in the middle).
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_gen #(
   parameter int HALF_PERIOD = 4,
   parameter int DIR_SETUP   = 8
) (
   input  logic       clk,
   input  logic       rst,
   pulse_gen_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_HIGH  = 2'd2,
      S_LOW   = 2'd3
   } state_t;

   localparam logic [15:0] c_setup_last = 16'(DIR_SETUP - 1);
   localparam logic [15:0] c_half       = 16'(HALF_PERIOD);

   state_t      r_state, w_state;
   logic [15:0] r_cnt,   w_cnt;
   logic [9:0]  r_remain, w_remain;
   logic [2:0]  r_motor, w_motor;
   logic [5:0]  r_puls,  w_puls;
   logic [5:0]  r_dirs,  w_dirs;
   logic        r_busy,  w_busy;
   logic        r_done,  w_done;
   logic [15:0] w_hlen;
   logic [5:0]  w_onehot;

   assign w_onehot = 6'(1) << r_motor;

`ifdef PULSE_GEN_RAMP_EN
   // Ramp: the half-period multiplier is fixed on entry to HIGH and held through LOW
   logic [9:0]  r_idx, w_idx_next, w_after;
   logic [1:0]  w_min;
   logic [15:0] r_hlen, w_hlen_new;
   logic        w_enter_high;

   assign w_enter_high = (w_state == S_HIGH) && (r_state != S_HIGH);
   assign w_idx_next   = (r_state == S_SETUP) ? 10'd0 : r_idx + 10'd1;
   assign w_after      = w_remain - 10'd1;
   assign w_hlen_new   = 16'(HALF_PERIOD * (32'd4 - 32'(w_min)));
   assign w_hlen       = r_hlen;

   // Multiplier index: min(pulse index, pulses remaining after it, 3)
   always_comb begin
      w_min = 2'd3;
      if (w_idx_next < 10'd3) w_min = w_idx_next[1:0];
      if (w_after < 10'(w_min)) w_min = w_after[1:0];
   end

   // Capture the phase length and pulse index when a new high phase starts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx  <= 10'd0;
         r_hlen <= c_half;
      end else if (w_enter_high) begin
         r_idx  <= w_idx_next;
         r_hlen <= w_hlen_new;
      end
   end
`else
   assign w_hlen = c_half;
`endif

   // Next-state and next-output logic; everything holds unless a phase ends
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_remain = r_remain;
      w_motor  = r_motor;
      w_puls   = r_puls;
      w_dirs   = r_dirs;
      w_busy   = r_busy;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Zero counts and illegal motors are dropped silently
            if (bus.Enable && (bus.PulseNum != 10'd0) && (bus.Motor <= 3'd5)) begin
               w_state  = S_SETUP;
               w_cnt    = 16'd0;
               w_remain = bus.PulseNum;
               w_motor  = bus.Motor;
               w_dirs   = bus.DRs;
               w_busy   = 1'b1;
            end
         end
         S_SETUP: begin
            if (r_cnt == c_setup_last) begin
               w_state = S_HIGH;
               w_cnt   = 16'd0;
               w_puls  = w_onehot;
            end else begin
               w_cnt = r_cnt + 16'd1;
            end
         end
         S_HIGH: begin
            if (r_cnt == w_hlen - 16'd1) begin
               w_state = S_LOW;
               w_cnt   = 16'd0;
               w_puls  = 6'd0;
            end else begin
               w_cnt = r_cnt + 16'd1;
            end
         end
         S_LOW: begin
            if (r_cnt == w_hlen - 16'd1) begin
               w_cnt    = 16'd0;
               w_remain = r_remain - 10'd1;
               if (r_remain == 10'd1) begin
                  w_state = S_IDLE;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
               end else begin
                  w_state = S_HIGH;
                  w_puls  = w_onehot;
               end
            end else begin
               w_cnt = r_cnt + 16'd1;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears every output immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_remain <= 10'd0;
         r_motor  <= 3'd0;
         r_puls   <= 6'd0;
         r_dirs   <= 6'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_remain <= w_remain;
         r_motor  <= w_motor;
         r_puls   <= w_puls;
         r_dirs   <= w_dirs;
         r_busy   <= w_busy;
         r_done   <= w_done;
      end
   end

   assign bus.PULs = r_puls;
   assign bus.DIRs = r_dirs;
   assign bus.Busy = r_busy;
   assign bus.Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_gen
// Description : Directed self-checking bench for pulse_gen with
//               HALF_PERIOD=2 and DIR_SETUP=3. Expected high-phase lengths
//               follow the ramp formula when PULSE_GEN_RAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_gen;

   localparam int HP = 2;
   localparam int DS = 3;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pulse_gen_if bus ();

   pulse_gen #(
      .HALF_PERIOD (HP),
      .DIR_SETUP   (DS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Half-period length of pulse k in a move of n pulses
   function automatic int h_exp(input int k, input int n);
`ifdef PULSE_GEN_RAMP_EN
      int m;
      m = k;
      if (n - 1 - k < m) m = n - 1 - k;
      if (m > 3) m = 3;
      return HP * (4 - m);
`else
      return HP;
`endif
   endfunction

   function automatic int busy_exp(input int n);
      int s;
      s = DS;
      for (int k = 0; k < n; k++) s += 2 * h_exp(k, n);
      return s;
   endfunction

   // Drive a request at a falling edge; check acceptance after the next rising edge
   task automatic start_move(input int m, input int n, input logic [5:0] drs);
      bus.Enable   = 1'b1;
      bus.Motor    = 3'(m);
      bus.PulseNum = 10'(n);
      bus.DRs      = drs;
      @(negedge clk);
      check_eq("busy_rise", int'(bus.Busy), 1);
      check_eq("dirs_load", int'(bus.DIRs), int'(drs));
   endtask

   // Called in the first Busy cycle; follows the move until Busy drops
   task automatic watch_move(input int ch, input int n, input int exp_busy);
      int   busy_len, setup_len, k, run, bad;
      logic p, prev, seen, timeout;
      busy_len = 0; setup_len = 0; k = 0; run = 0; bad = 0;
      prev = 1'b0; seen = 1'b0; timeout = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (bus.Busy !== 1'b1) begin
            timeout = 1'b0;
            break;
         end
         busy_len++;
         p = bus.PULs[ch];
         if ((bus.PULs & ~(6'(1) << ch)) != 6'd0) bad++;
         if (p) begin
            run  = prev ? run + 1 : 1;
            seen = 1'b1;
         end else begin
            if (prev) begin
               check_eq("high_len", run, h_exp(k, n));
               k++;
            end
            if (!seen) setup_len++;
         end
         prev = p;
         @(negedge clk);
      end
      check_eq("move_timeout", int'(timeout), 0);
      check_eq("busy_len", busy_len, exp_busy);
      check_eq("setup_len", setup_len, DS);
      check_eq("pulse_count", k, n);
      check_eq("other_channels", bad, 0);
      check_eq("puls_after", int'(bus.PULs), 0);
      check_eq("done_strobe", int'(bus.Done), 1);
   endtask

   initial begin
      int found;
      n_checks = 0;
      n_fail   = 0;
      rst          = 1'b0;
      bus.Enable   = 1'b0;
      bus.Motor    = 3'd0;
      bus.PulseNum = 10'd0;
      bus.DRs      = 6'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_puls", int'(bus.PULs), 0);
      check_eq("rst_dirs", int'(bus.DIRs), 0);
      check_eq("rst_busy", int'(bus.Busy), 0);
      check_eq("rst_done", int'(bus.Done), 0);
      rst = 1'b1;
      @(negedge clk);

      // Basic move: motor 2, 5 pulses
      start_move(2, 5, 6'b000100);
      bus.Enable = 1'b0;
`ifdef PULSE_GEN_RAMP_EN
      watch_move(2, 5, 67);
`else
      watch_move(2, 5, 23);
`endif
      @(negedge clk);
      check_eq("done_single", int'(bus.Done), 0);
      check_eq("idle_busy", int'(bus.Busy), 0);

      // Zero count and illegal motor are both dropped
      bus.Enable = 1'b1; bus.Motor = 3'd2; bus.PulseNum = 10'd0; bus.DRs = 6'b111111;
      found = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.Busy || bus.Done || (bus.PULs != 6'd0)) found++;
      end
      check_eq("drop_zero", found, 0);
      bus.Motor = 3'd6; bus.PulseNum = 10'd5;
      found = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.Busy || bus.Done || (bus.PULs != 6'd0)) found++;
      end
      check_eq("drop_motor6", found, 0);
      check_eq("dirs_hold", int'(bus.DIRs), 6'b000100);
      bus.Enable = 1'b0;
      @(negedge clk);

      // Inputs changed mid-move must be ignored
      start_move(1, 3, 6'b101010);
      bus.Enable = 1'b0;
      fork
         watch_move(1, 3, busy_exp(3));
         begin
            repeat (3) @(negedge clk);
            bus.Motor = 3'd4; bus.PulseNum = 10'd100; bus.DRs = 6'b010101;
            repeat (3) @(negedge clk);
            bus.Enable = 1'b1;
            repeat (2) @(negedge clk);
            bus.Enable = 1'b0;
         end
      join
      check_eq("dirs_unchanged", int'(bus.DIRs), 6'b101010);
      @(negedge clk);

      // Asynchronous reset in the middle of a high phase
      start_move(3, 4, 6'b001000);
      bus.Enable = 1'b0;
      found = 0;
      for (int c = 0; c < 50; c++) begin
         if (bus.PULs[3]) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check_eq("reach_high", found, 1);
      #1 rst = 1'b0;
      #1;
      check_eq("arst_puls", int'(bus.PULs), 0);
      check_eq("arst_busy", int'(bus.Busy), 0);
      check_eq("arst_dirs", int'(bus.DIRs), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("no_resume", int'(bus.Busy), 0);
      start_move(1, 1, 6'b000010);
      bus.Enable = 1'b0;
      watch_move(1, 1, busy_exp(1));
      @(negedge clk);

      // Back-to-back moves with Enable held high
      start_move(0, 1, 6'b100001);
      bus.Motor = 3'd5;
      watch_move(0, 1, busy_exp(1));
      @(negedge clk);
      check_eq("b2b_busy", int'(bus.Busy), 1);
      check_eq("b2b_done_low", int'(bus.Done), 0);
      bus.Enable = 1'b0;
      watch_move(5, 1, busy_exp(1));
      @(negedge clk);
      check_eq("final_done", int'(bus.Done), 0);
      check_eq("final_busy", int'(bus.Busy), 0);
      check_eq("final_dirs", int'(bus.DIRs), 6'b100001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
